// File: rtl/maze_job_scheduler.sv
// Maze job scheduler: arbitrates two requesters onto one shared maze solver,
// runs each job under a cycle budget and returns the result over a
// valid/ready handshake. Only one job is in flight at a time.
//
// state | meaning
// IDLE  | solver held in reset, waiting for a request to grant
// LOAD  | maze latched, one-cycle solver reset pulse, cycle counter cleared
// RUN   | solver released, cycles counted until done or timeout
// RESP  | result presented, held until the consumer takes it
module maze_job_scheduler #(
  parameter int SIZE    = 9,
  parameter int N       = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [SIZE*SIZE-1:0]   req_maze0,
  input  logic [SIZE*SIZE-1:0]   req_maze1,
  output logic [SIZE*SIZE-1:0]   slv_maze,
  output logic                   slv_rst,
  input  logic                   slv_done,
  input  logic [N-1:0]           slv_x,
  input  logic [N-1:0]           slv_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic                   rsp_ok,
  output logic [N-1:0]           rsp_x,
  output logic [N-1:0]           rsp_y,
  output logic [15:0]            rsp_cycles
);

  localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t state, state_nx;
  logic   ptr;
  logic   gnt;
  logic   accept;
  logic   timed_out;

  // Round-robin pick: favoured requester on contention, else whoever is asking.
  always_comb begin
    gnt = req_valid[1];
    if (req_valid == 2'b11) gnt = ptr;
  end

  assign timed_out = (rsp_cycles == LAST_CYCLE);
  assign rsp_valid = (state == RESP);

  // Next-state and request handshake; ready is withheld while reset is high.
  always_comb begin
    state_nx  = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && req_valid[gnt]) begin
          req_ready = gnt ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_nx  = LOAD;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        if (slv_done || timed_out) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; solver reset is registered from the next state so it
  // drops exactly for the RUN cycles without combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      slv_rst <= 1'b1;
    end else begin
      state   <= state_nx;
      slv_rst <= (state_nx != RUN);
    end
  end

  // Job datapath: maze and requester capture, cycle counting, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      slv_maze   <= '0;
      rsp_id     <= 1'b0;
      rsp_ok     <= 1'b0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            slv_maze <= gnt ? req_maze1 : req_maze0;
            rsp_id   <= gnt;
          end
        end
        LOAD: rsp_cycles <= '0;
        RUN: begin
          if (slv_done) begin
            rsp_ok <= 1'b1;
            rsp_x  <= slv_x;
            rsp_y  <= slv_y;
          end else if (timed_out) begin
            rsp_ok <= 1'b0;
          end else if (rsp_cycles != 16'hFFFF) begin
            rsp_cycles <= rsp_cycles + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) ptr <= ~rsp_id;
        end
        default: ;
      endcase
    end
  end

endmodule
